pausible_rx_port: RTL and testbench

PAUSIBLE_RX_PORT -- requirements
Module: pausible_rx_port

---
 rtl/pausible_rx_port.sv | 88 ++++++++
 tb/tb_pausible_rx_port.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pausible_rx_port.sv
// Pausible-clock receive port: 4-phase async sender captured through a
// clock-pausing mutex into a small FIFO drained by a valid/ready consumer.
module pausible_rx_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         ch_req,
    input  logic [WIDTH-1:0]             ch_data,
    output logic                         ch_ack,
    output logic                         mx_req,
    input  logic                         mx_grant,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         grant_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ack_q, ack_d;
    logic             gerr_q, gerr_d;
    logic             full, phase_evt, push, pop;

    // ch_req only reaches state through mx_req, which the mutex settles
    assign full      = (level_q == LW'(DEPTH));
    assign mx_req    = (ch_req & ~ack_q & ~full) | (~ch_req & ack_q);
    assign phase_evt = mx_grant & mx_req & ~rst;
    assign push      = phase_evt & ~ack_q;
    assign pop       = out_valid & out_ready & ~rst;

    assign ch_ack    = ack_q;
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rptr_q];
    assign level     = level_q;
    assign grant_err = gerr_q;

    always_comb begin
        ack_d   = ack_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        gerr_d  = gerr_q | (mx_grant & ~mx_req);
        if (phase_evt) begin
            ack_d = ~ack_q;
        end
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ack_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            gerr_q  <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            gerr_q  <= gerr_d;
        end
    end

    // storage survives reset; only the pointers are cleared
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= ch_data;
        end
    end
endmodule

// File: tb/tb_pausible_rx_port.sv
// Directed and randomized bench for pausible_rx_port against a
// queue-based handshake/FIFO reference model.
module tb_pausible_rx_port;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             ch_req = 1'b0;
    logic [WIDTH-1:0] ch_data = '0;
    logic             ch_ack;
    logic             mx_req;
    logic             mx_grant = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       level;
    logic             grant_err;

    pausible_rx_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .rst       (rst),
        .ch_req    (ch_req),
        .ch_data   (ch_data),
        .ch_ack    (ch_ack),
        .mx_req    (mx_req),
        .mx_grant  (mx_grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .grant_err (grant_err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [WIDTH-1:0] q[$];
    logic             m_ack = 1'b0;
    logic             m_gerr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock cycle; g: 0 no grant, 1 forced grant, 2 mutex grants if requested
    task automatic cyc(input logic r, input logic [WIDTH-1:0] d, input int g,
                       input logic rdy, input logic rs);
        logic mxr, gr, pop, push;
        ch_req    = r;
        ch_data   = d;
        out_ready = rdy;
        rst       = rs;
        mxr = (r && !m_ack && q.size() < DEPTH) || (!r && m_ack);
        gr  = (g == 1) ? 1'b1 : ((g == 2) ? mxr : 1'b0);
        mx_grant = gr;
        #1;
        if (!rs) chk("mx_req", 32'(mx_req), 32'(mxr));
        if (rs) begin
            m_ack  = 1'b0;
            m_gerr = 1'b0;
            q.delete();
        end else begin
            if (gr && !mxr) m_gerr = 1'b1;
            pop  = (q.size() != 0) && rdy;
            push = gr && mxr && !m_ack;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
            if (gr && mxr) m_ack = !m_ack;
        end
        @(negedge clock);
        chk("ch_ack", 32'(ch_ack), 32'(m_ack));
        chk("level", 32'(level), q.size());
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        chk("grant_err", 32'(grant_err), 32'(m_gerr));
        chk("level_max", 32'(level <= 3'(DEPTH)), 32'd1);
    endtask

    task automatic xfer(input logic [WIDTH-1:0] d, input logic rdy);
        cyc(1'b1, d, 0, rdy, 1'b0);
        cyc(1'b1, d, 2, rdy, 1'b0);
        cyc(1'b0, d, 0, rdy, 1'b0);
        cyc(1'b0, d, 2, rdy, 1'b0);
    endtask

    initial begin
        logic             s_req;
        logic [WIDTH-1:0] s_data;
        @(negedge clock);
        cyc(1'b0, 8'h00, 0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 0, 1'b0, 1'b1);

        // single transfer
        xfer(8'hA5, 1'b0);
        cyc(1'b0, 8'h00, 0, 1'b1, 1'b0);

        // fill, stall the fifth word, pop to release it
        for (int i = 0; i < DEPTH; i++) xfer(8'h10 + 8'(i), 1'b0);
        cyc(1'b1, 8'h55, 2, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 2, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 2, 1'b1, 1'b0);
        cyc(1'b1, 8'h55, 2, 1'b0, 1'b0);
        cyc(1'b0, 8'h55, 2, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 8'h00, 0, 1'b1, 1'b0);

        // simultaneous push and pop at level 2
        xfer(8'h01, 1'b0);
        xfer(8'h02, 1'b0);
        cyc(1'b1, 8'h03, 0, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 2, 1'b1, 1'b0);
        cyc(1'b0, 8'h03, 2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 0, 1'b1, 1'b0);

        // wrap-around with continuous drain
        for (int i = 0; i < 10; i++) xfer(8'(i), 1'b1);
        cyc(1'b0, 8'h00, 0, 1'b1, 1'b0);

        // stray grant sets a sticky error cleared only by reset
        cyc(1'b0, 8'h00, 1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 0, 1'b0, 1'b0);
        xfer(8'h77, 1'b1);
        cyc(1'b0, 8'h00, 0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 0, 1'b0, 1'b0);

        // reset in ACKED with ch_req held: word is captured again
        cyc(1'b1, 8'hC3, 0, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 2, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 0, 1'b0, 1'b1);
        cyc(1'b1, 8'hC3, 2, 1'b0, 1'b0);
        cyc(1'b0, 8'hC3, 2, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 0, 1'b1, 1'b0);

        // randomized protocol-legal sender, mutex and consumer
        s_req  = 1'b0;
        s_data = '0;
        for (int i = 0; i < 400; i++) begin
            if (s_req == m_ack && $urandom_range(0, 1) == 1) begin
                s_req = ~s_req;
                if (s_req) s_data = WIDTH'($urandom);
            end
            cyc(s_req, s_data, ($urandom_range(0, 3) != 0) ? 2 : 0,
                1'($urandom_range(0, 2) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
